// File: rtl/run_det_pkg.sv
// Shared types and sizing helpers for the run-of-identical-bits detector.
package run_det_pkg;

    typedef enum logic {
        RD_IDLE,
        RD_TRACK
    } rd_state_t;

    // run_cnt must be able to hold RUN_LEN itself (overlap mode saturates there)
    function automatic int rc_width(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/run_detector_if.sv
// Bit-stream and result signals of run_detector; hit_count exists only
// when RUN_DET_HITCNT_EN is defined.
interface run_detector_if
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
);
    localparam int RC_W = rc_width(RUN_LEN);

    logic            in_valid;
    logic            in_bit;
    logic            overlap_en;
    logic            clear;
    logic            detect;
    logic            detect_val;
    logic [RC_W-1:0] run_cnt;
`ifdef RUN_DET_HITCNT_EN
    logic [CNT_W-1:0] hit_count;

    modport master (
        output in_valid, in_bit, overlap_en, clear,
        input  detect, detect_val, run_cnt, hit_count
    );
    modport slave (
        input  in_valid, in_bit, overlap_en, clear,
        output detect, detect_val, run_cnt, hit_count
    );
`else
    modport master (
        output in_valid, in_bit, overlap_en, clear,
        input  detect, detect_val, run_cnt
    );
    modport slave (
        input  in_valid, in_bit, overlap_en, clear,
        output detect, detect_val, run_cnt
    );
`endif
endinterface

// File: rtl/run_det_sat_ctr.sv
// Generic saturating up-counter with synchronous active-high reset.
module run_det_sat_ctr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_inc && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/run_detector.sv
// Detects RUN_LEN consecutive identical valid bits, overlapping or not.
// Optional saturating hit counter is compiled in with RUN_DET_HITCNT_EN.
module run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    run_detector_if.slave bus
);
    localparam int              RC_W = rc_width(RUN_LEN);
    localparam logic [RC_W-1:0] RL_C = RC_W'(RUN_LEN);
    localparam logic [RC_W:0]   RL_N = (RC_W+1)'(RUN_LEN);

    rd_state_t       r_state, w_state_nxt;
    logic            r_last_bit, w_last_nxt;
    logic [RC_W-1:0] r_run_cnt, w_cnt_nxt;
    logic            r_detect, w_det_nxt;
    logic            r_detect_val, w_dval_nxt;
    logic [RC_W:0]   w_n;

    assign w_n = {1'b0, r_run_cnt} + (RC_W+1)'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_bit;
        w_cnt_nxt   = r_run_cnt;
        w_det_nxt   = 1'b0;
        w_dval_nxt  = r_detect_val;
        if (bus.clear) begin
            // beat arriving with clear is dropped
            w_state_nxt = RD_IDLE;
            w_cnt_nxt   = '0;
        end else if (bus.in_valid) begin
            case (r_state)
                RD_IDLE: begin
                    w_state_nxt = RD_TRACK;
                    w_last_nxt  = bus.in_bit;
                    w_cnt_nxt   = RC_W'(1);
                end
                default: begin
                    if (bus.in_bit != r_last_bit) begin
                        w_last_nxt = bus.in_bit;
                        w_cnt_nxt  = RC_W'(1);
                    end else if (w_n < RL_N) begin
                        w_cnt_nxt = w_n[RC_W-1:0];
                    end else begin
                        w_det_nxt  = 1'b1;
                        w_dval_nxt = r_last_bit;
                        // non-overlap restarts from 0 so the next match counts as 1
                        w_cnt_nxt  = bus.overlap_en ? RL_C : '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RD_IDLE;
            r_last_bit   <= 1'b0;
            r_run_cnt    <= '0;
            r_detect     <= 1'b0;
            r_detect_val <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_bit   <= w_last_nxt;
            r_run_cnt    <= w_cnt_nxt;
            r_detect     <= w_det_nxt;
            r_detect_val <= w_dval_nxt;
        end
    end

    assign bus.detect     = r_detect;
    assign bus.detect_val = r_detect_val;
    assign bus.run_cnt    = r_run_cnt;

`ifdef RUN_DET_HITCNT_EN
    run_det_sat_ctr #(.CNT_W(CNT_W)) u_hit_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_det_nxt),
        .o_count (bus.hit_count)
    );
`endif
endmodule

// File: tb/tb_run_detector.sv
// Three detectors (RUN_LEN 2,3,4, CNT_W 2) share one stimulus stream;
// a run-length reference model feeds a scoreboard checked by a monitor.
module tb_run_detector;
    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, clear = 1'b0, in_valid = 1'b0, in_bit = 1'b0, overlap_en = 1'b0;

    logic [NL-1:0]            det, dv;
    logic [NL-1:0][2:0]       cnt;
    logic [NL-1:0][1:0]       hit;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int L = g + 2;
        run_detector_if #(.RUN_LEN(L), .CNT_W(2)) bus ();
        run_detector #(.RUN_LEN(L), .CNT_W(2)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
        assign bus.in_valid   = in_valid;
        assign bus.in_bit     = in_bit;
        assign bus.overlap_en = overlap_en;
        assign bus.clear      = clear;
        assign det[g] = bus.detect;
        assign dv[g]  = bus.detect_val;
        assign cnt[g] = 3'(bus.run_cnt);
`ifdef RUN_DET_HITCNT_EN
        assign hit[g] = bus.hit_count;
`else
        assign hit[g] = 2'b00;
`endif
    end

    typedef struct packed {
        logic [NL-1:0]      det;
        logic [NL-1:0]      dv;
        logic [NL-1:0][2:0] cnt;
        logic [NL-1:0][1:0] hit;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;

    // model: length of the current identical run, and where the last
    // non-overlapping detection ended inside it
    bit tracking[NL], lastb[NL], dval_m[NL];
    int run[NL], mark[NL], hits[NL];

    task automatic beat(input bit r, input bit c, input bit v, input bit b, input bit ov);
        exp_t e;
        @(negedge clk);
        reset = r; clear = c; in_valid = v; in_bit = b; overlap_en = ov;
        e = '0;
        for (int l = 0; l < NL; l++) begin
            int len = l + 2;
            if (r) begin
                tracking[l] = 0; lastb[l] = 0; run[l] = 0; mark[l] = 0;
                hits[l] = 0; dval_m[l] = 0;
            end else if (c) begin
                tracking[l] = 0; run[l] = 0; mark[l] = 0;
            end else if (v) begin
                if (!tracking[l] || b != lastb[l]) begin
                    tracking[l] = 1; lastb[l] = b; run[l] = 1; mark[l] = 0;
                end else begin
                    run[l]++;
                    if (run[l] - mark[l] >= len) begin
                        e.det[l] = 1'b1;
                        dval_m[l] = b;
                        if (!ov) mark[l] = run[l];
                        if (hits[l] < 3) hits[l]++;
                    end
                end
            end
            e.dv[l]  = dval_m[l];
            e.cnt[l] = 3'((run[l] - mark[l] < len) ? run[l] - mark[l] : len);
            e.hit[l] = 2'(hits[l]);
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int l = 0; l < NL; l++) begin
                    bit ok;
                    ok = (det[l] === e.det[l]) && (cnt[l] === e.cnt[l]);
                    if (e.det[l]) ok = ok && (dv[l] === e.dv[l]);
`ifdef RUN_DET_HITCNT_EN
                    ok = ok && (hit[l] === e.hit[l]);
`endif
                    total++;
                    if (!ok) begin
                        bad++;
                        $display("FAIL lane_len%0d t=%0t det/val/cnt/hit got=%b/%b/%0d/%0d want=%b/%b/%0d/%0d",
                                 l + 2, $time, det[l], dv[l], cnt[l], hit[l],
                                 e.det[l], e.dv[l], e.cnt[l], e.hit[l]);
                    end
                end
            end
        end
    end

    task automatic stream(input bit ov, input int n, input bit b);
        for (int i = 0; i < n; i++) beat(0, 0, 1, b, ov);
    endtask

    initial begin : stim
        bit pb, ov;
        // legacy pattern 0,0,1,1,1,1 non-overlapping
        beat(1, 0, 0, 0, 0);
        stream(0, 2, 0); stream(0, 4, 1);
        // overlapping run of ones
        beat(1, 0, 0, 0, 0);
        stream(1, 5, 1);
        // valid gap mid-run
        beat(1, 0, 0, 0, 0);
        stream(0, 2, 1);
        for (int i = 0; i < 4; i++) beat(0, 0, 0, 1, 0);
        stream(0, 2, 1);
        // clear with a beat attached, then fresh run
        beat(1, 0, 0, 0, 0);
        stream(0, 3, 0);
        beat(0, 1, 1, 0, 0);
        stream(0, 4, 0);
        // reset on the completing beat with clear also high
        beat(1, 0, 0, 0, 0);
        stream(0, 2, 1);
        beat(1, 1, 1, 1, 1);
        beat(0, 0, 0, 0, 0);
        // long overlapping run saturates the hit counter
        stream(1, 10, 0);
        beat(0, 1, 0, 0, 0);
        stream(1, 3, 1);
        // randomized traffic, biased toward repeated bits
        pb = 0; ov = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r, c, v;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 99) < 3);
            v = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            if ($urandom_range(0, 9) == 0) ov = ~ov;
            beat(r, c, v, pb, ov);
        end
        beat(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
